window_fetch_ctrl: RTL and testbench

Sequencing controller for the 3x3 pixel-window builder in the edge-detection pipeline. On `start` it walks every interior pixel centre of an image stored in pixel memory. For each centre it fetches the nine neighbourhood pixels over a request/acknowledge memory handshake and streams them into the window concatenator by driving the tap counter's `clear`/`count_enable`. It then holds `window_valid` until the Sobel stage accepts the window.

---
 rtl/window_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_window_fetch_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window_fetch_ctrl.sv
// Sequencer for the 3x3 window builder: walks every interior pixel centre,
// fetches its nine neighbours over a req/ack handshake and presents the window.
module window_fetch_ctrl #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pixel,
  output logic              count_enable,
  output logic              clear,
  output logic              window_valid,
  input  logic              window_ready,
  output logic [15:0]       out_x,
  output logic [15:0]       out_y,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, CLEAR, REQ, LOAD, PRESENT, NEXT, DONE} state_t;

  state_t     state;
  logic [3:0] tap;

  // Taps are row-major around the centre, so tap t sits at row t/3, column t%3.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [15:0] x, input logic [15:0] y,
                                                 input logic [3:0] t);
    logic [ADDR_W-1:0] r;
    logic [ADDR_W-1:0] c;
    case (t)
      4'd0, 4'd1, 4'd2: r = '0;
      4'd3, 4'd4, 4'd5: r = ADDR_W'(1);
      default:          r = ADDR_W'(2);
    endcase
    case (t)
      4'd0, 4'd3, 4'd6: c = '0;
      4'd1, 4'd4, 4'd7: c = ADDR_W'(1);
      default:          c = ADDR_W'(2);
    endcase
    return (ADDR_W'(y) + r - ADDR_W'(1)) * ADDR_W'(IMG_W) + ADDR_W'(x) + c - ADDR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      tap          <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      pixel        <= '0;
      count_enable <= 1'b0;
      clear        <= 1'b0;
      window_valid <= 1'b0;
      out_x        <= '0;
      out_y        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      clear        <= 1'b0;
      count_enable <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            out_x <= 16'd1;
            out_y <= 16'd1;
            tap   <= '0;
            clear <= 1'b1;
            busy  <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          mem_req  <= 1'b1;
          mem_addr <= tap_addr(out_x, out_y, 4'd0);
          state    <= REQ;
        end
        REQ: begin
          if (mem_ack) begin
            pixel        <= mem_rdata;
            mem_req      <= 1'b0;
            count_enable <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (tap == 4'd8) begin
            window_valid <= 1'b1;
            state        <= PRESENT;
          end else begin
            tap      <= tap + 4'd1;
            mem_req  <= 1'b1;
            mem_addr <= tap_addr(out_x, out_y, tap + 4'd1);
            state    <= REQ;
          end
        end
        PRESENT: begin
          if (window_ready) begin
            window_valid <= 1'b0;
            state        <= NEXT;
          end
        end
        NEXT: begin
          if (out_x < 16'(IMG_W - 2)) begin
            out_x <= out_x + 16'd1;
          end else begin
            out_x <= 16'd1;
            out_y <= out_y + 16'd1;
          end
          // The coordinates are advanced even after the last window; DONE freezes them.
          if (out_x == 16'(IMG_W - 2) && out_y == 16'(IMG_H - 2)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            tap   <= '0;
            clear <= 1'b1;
            state <= CLEAR;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_req      <= 1'b0;
          window_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Directed bench for window_fetch_ctrl on a 4x4 image, with a scoreboard of
// expected fetch addresses, pixels and window centres.
module tb_window_fetch_ctrl;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              start;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [7:0]        pixel;
  logic              count_enable;
  logic              clear;
  logic              window_valid;
  logic              window_ready;
  logic [15:0]       out_x;
  logic [15:0]       out_y;
  logic              busy;
  logic              done;

  int checks = 0;
  int failures = 0;

  int ack_wait = 0;
  logic force_ack = 1'b0;
  int req_cnt;

  logic [31:0] addr_q[$];
  logic [31:0] win_q[$];
  logic [7:0]  pix_q[$];

  int win_cnt = 0, done_cnt = 0, clear_cnt = 0, ce_cnt = 0;
  int win_base, done_base, clear_base, ce_base;
  int req_len = 0;
  logic [31:0] held_addr = '0;

  window_fetch_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pixel(pixel), .count_enable(count_enable), .clear(clear),
    .window_valid(window_valid), .window_ready(window_ready),
    .out_x(out_x), .out_y(out_y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix_of(input logic [31:0] a);
    return 8'((a * 32'd37) + 32'h5a);
  endfunction

  // Memory model: acks after ack_wait extra cycles of a held request.
  assign mem_rdata = pix_of(32'(mem_addr));
  assign mem_ack   = force_ack | (mem_req && (req_cnt == ack_wait));

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) req_cnt <= 0;
    else if (mem_req && !mem_ack) req_cnt <= req_cnt + 1;
    else req_cnt <= 0;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    logic [31:0] ea;
    logic [31:0] ew;
    logic [7:0]  ep;
    if (!n_rst) begin
      req_len = 0;
    end else begin
      if (mem_req) begin
        if (req_len > 0) check_output("addr_stable", 32'(mem_addr), held_addr);
        held_addr = 32'(mem_addr);
        req_len++;
        if (mem_ack) begin
          if (addr_q.size() == 0) begin
            check_output("addr_unexpected", 32'(mem_addr), 32'hffff_ffff);
          end else begin
            ea = addr_q.pop_front();
            check_output("mem_addr", 32'(mem_addr), ea);
            pix_q.push_back(pix_of(ea));
          end
          check_output("req_len", 32'(req_len), 32'(ack_wait + 1));
          req_len = 0;
        end
      end
      if (count_enable) begin
        ce_cnt++;
        if (pix_q.size() == 0) begin
          check_output("ce_unexpected", 32'(count_enable), 32'd0);
        end else begin
          ep = pix_q.pop_front();
          check_output("pixel", 32'(pixel), 32'(ep));
        end
      end
      if (clear) clear_cnt++;
      if (done) done_cnt++;
      if (window_valid && window_ready) begin
        win_cnt++;
        if (win_q.size() == 0) begin
          check_output("win_unexpected", {out_x, out_y}, 32'hffff_ffff);
        end else begin
          ew = win_q.pop_front();
          check_output("window_xy", {out_x, out_y}, ew);
        end
      end
    end
  end

  task automatic apply_stimulus();
    for (int y = 1; y <= IMG_H - 2; y++) begin
      for (int x = 1; x <= IMG_W - 2; x++) begin
        win_q.push_back({16'(x), 16'(y)});
        for (int t = 0; t < 9; t++)
          addr_q.push_back(32'((y - 1 + t / 3) * IMG_W + (x - 1 + t % 3)));
      end
    end
    win_base = win_cnt; done_base = done_cnt; clear_base = clear_cnt; ce_base = ce_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic measure_latency(input string tag, input int expected);
    int n = 0;
    while (!window_valid && n < 500) begin
      @(posedge clk);
      #1 n++;
    end
    check_output(tag, 32'(n), 32'(expected));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    check_output(tag, 32'(done_cnt != done_base), 32'd1);
  endtask

  task automatic frame_summary(input string tag);
    @(posedge clk);
    #1;
    check_output({tag, "_windows"}, 32'(win_cnt - win_base), 32'd4);
    check_output({tag, "_done"}, 32'(done_cnt - done_base), 32'd1);
    check_output({tag, "_clears"}, 32'(clear_cnt - clear_base), 32'd4);
    check_output({tag, "_count_en"}, 32'(ce_cnt - ce_base), 32'd36);
    check_output({tag, "_queues"}, 32'(addr_q.size() + win_q.size() + pix_q.size()), 32'd0);
    check_output({tag, "_idle"}, {busy, mem_req, window_valid}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_ctl"}, {mem_req, count_enable, clear, window_valid, busy, done}, 32'd0);
    check_output({tag, "_addr_pix"}, {20'd0, 32'(mem_addr) << 8 | 32'(pixel)}, 32'd0);
    check_output({tag, "_xy"}, {out_x, out_y}, 32'd0);
  endtask

  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    window_ready = 1'b0;

    // Reset, then idle with handshake inputs wiggling.
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 force_ack = i[0];
      window_ready = ~i[0];
      @(negedge clk);
      check_all_zero("idle");
    end
    force_ack = 1'b0;

    // Zero-wait memory, window_ready tied high.
    window_ready = 1'b1;
    ack_wait = 0;
    apply_stimulus();
    check_output("start_clear", {out_x, out_y, 15'd0, clear}, {16'd1, 16'd1} | 32'd1);
    measure_latency("latency_zero_wait", 19);
    wait_done("done_zero_wait", 400);
    frame_summary("fast");

    // Three-cycle memory wait.
    ack_wait = 2;
    apply_stimulus();
    measure_latency("latency_wait3", 37);
    wait_done("done_wait3", 800);
    frame_summary("wait3");

    // Backpressure with spurious start and ack while the window is held.
    ack_wait = 0;
    window_ready = 1'b0;
    apply_stimulus();
    measure_latency("latency_bp", 19);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) start = 1'b1;
      if (i == 4) start = 1'b0;
      force_ack = (i >= 5 && i <= 7);
      @(negedge clk);
      check_output("bp_hold", {window_valid, mem_req, count_enable, busy},
                   {1'b1, 1'b0, 1'b0, 1'b1});
      check_output("bp_xy", {out_x, out_y}, {16'd1, 16'd1});
      @(posedge clk);
      #1;
    end
    force_ack = 1'b0;
    start = 1'b0;
    window_ready = 1'b1;
    wait_done("done_bp", 400);
    frame_summary("bp");

    // Asynchronous reset while fetching window 2.
    ack_wait = 2;
    apply_stimulus();
    begin
      int n = 0;
      while (!(win_cnt > win_base && mem_req) && n < 400) begin
        @(posedge clk);
        #1 n++;
      end
      check_output("reached_win2_req", 32'(win_cnt - win_base), 32'd1);
    end
    #2 n_rst = 1'b0;
    #1 check_all_zero("async_reset");
    addr_q.delete();
    win_q.delete();
    pix_q.delete();
    repeat (2) @(posedge clk);
    #1 check_output("reset_no_done", 32'(done_cnt - done_base), 32'd0);
    n_rst = 1'b1;
    ack_wait = 0;
    apply_stimulus();
    check_output("restart_xy", {out_x, out_y}, {16'd1, 16'd1});
    @(posedge clk);
    #1 check_output("restart_addr", {31'd0, mem_req} | (32'(mem_addr) << 1), 32'd1);
    wait_done("done_restart", 400);
    frame_summary("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
